// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-collector clock/data output enables.
// Define PS2_TX_ACK_CHECK_EN to turn a device NACK into errTx; undefined, only a timeout gives errTx.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startTx,
  input  logic [7:0] txData,
  output logic       busy,
  output logic       doneTx,
  output logic       errTx,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERR
  } txStateT;

  txStateT          state, nextState;
  logic [1:0]       clkSync, dataSync;
  logic             clkPrev;
  logic             clkLine, dataLine, clkFall;
  logic [9:0]       shiftReg;
  logic [3:0]       edgeCnt;
  logic             dataOeReg;
  logic [CNT_W-1:0] cycleCnt;
  logic             inhibitDone, timeoutHit, nack;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value, forming a real pipeline.
      clkSync  <= {clkSync[0], ps2ClkIn};
      dataSync <= {dataSync[0], ps2DataIn};
      clkPrev  <= clkSync[1];
    end
  end

  assign clkLine  = clkSync[1];
  assign dataLine = dataSync[1];
  assign clkFall  = clkPrev & ~clkLine;

  // One counter times the inhibit phase, then restarts in RTS as the frame timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt <= '0;
    end else begin
      case (state)
        INHIBIT, SEND, ACK, WAIT_IDLE: cycleCnt <= cycleCnt + CNT_W'(1);
        default:                       cycleCnt <= '0;
      endcase
    end
  end

  assign inhibitDone = (cycleCnt == CNT_W'(INHIBIT_CYCLES - 1));
  assign timeoutHit  = (cycleCnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg  <= '0;
      edgeCnt   <= '0;
      dataOeReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          edgeCnt   <= '0;
          dataOeReg <= 1'b0;
          if (startTx) shiftReg <= {1'b1, ~^txData, txData};
        end
        RTS: begin
          edgeCnt   <= '0;
          dataOeReg <= 1'b1;
        end
        SEND: begin
          // Edges 1..10 shift out D0..D7, parity, then the stop bit (releases data).
          if (clkFall && edgeCnt < 4'd10) begin
            dataOeReg <= ~shiftReg[0];
            shiftReg  <= {1'b0, shiftReg[9:1]};
            edgeCnt   <= edgeCnt + 4'd1;
          end
        end
        default: begin
          edgeCnt   <= '0;
          dataOeReg <= 1'b0;
        end
      endcase
    end
  end

`ifdef PS2_TX_ACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)               nack <= 1'b0;
    else if (state == ACK) nack <= dataLine;
  end
`else
  assign nack = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      IDLE:      if (startTx) nextState = INHIBIT;
      INHIBIT:   if (inhibitDone) nextState = RTS;
      RTS:       nextState = SEND;
      SEND: begin
        if (timeoutHit)                       nextState = ERR;
        else if (clkFall && edgeCnt == 4'd10) nextState = ACK;
      end
      ACK:       nextState = timeoutHit ? ERR : WAIT_IDLE;
      WAIT_IDLE: begin
        if (timeoutHit)              nextState = ERR;
        else if (clkLine && dataLine) nextState = nack ? ERR : DONE;
      end
      DONE, ERR: nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    doneTx    = 1'b0;
    errTx     = 1'b0;
    ps2ClkOe  = 1'b0;
    ps2DataOe = 1'b0;
    case (state)
      INHIBIT: begin
        busy     = 1'b1;
        ps2ClkOe = 1'b1;
      end
      RTS: begin
        busy      = 1'b1;
        ps2ClkOe  = 1'b1;
        ps2DataOe = 1'b1;
      end
      SEND: begin
        busy      = 1'b1;
        ps2DataOe = dataOeReg & ~timeoutHit;
      end
      ACK, WAIT_IDLE: busy = 1'b1;
      DONE:           doneTx = 1'b1;
      ERR:            errTx = 1'b1;
      default:        ;
    endcase
  end

endmodule
